mem_arbiter: RTL and testbench

- Two-requester arbiter in front of the single-port word-addressed block RAM (1-cycle registered read, read-first on write).
- Port 0 is the program loader / instruction side; port 1 is the core load/store unit.
- Shares the RAM port using round-robin arbitration, with an optional lock for atomic read-modify-write sequences.
- Returns a response to the granted requester exactly one cycle after acceptance.

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter with atomic lock in front of a single-port
// read-first block RAM with a 1-cycle registered read.
module mem_arbiter #(
    parameter int unsigned MEM_DEPTH = 262144,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             p0_valid,
    output logic             p0_ready,
    input  logic             p0_we,
    input  logic             p0_lock,
    input  logic [31:0]      p0_addr,
    input  logic [31:0]      p0_wdata,
    output logic             p0_rvalid,
    output logic [31:0]      p0_rdata,
    output logic             p0_err,
    input  logic             p1_valid,
    output logic             p1_ready,
    input  logic             p1_we,
    input  logic             p1_lock,
    input  logic [31:0]      p1_addr,
    input  logic [31:0]      p1_wdata,
    output logic             p1_rvalid,
    output logic [31:0]      p1_rdata,
    output logic             p1_err,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] p0_grants,
    output logic [CNT_W-1:0] p1_grants
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] DEPTH_L = AW'(MEM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             rr_q, rr_d;            // 0: port 0 wins a tie, 1: port 1 wins
    logic             p0_rvalid_q, p0_rvalid_d;
    logic             p1_rvalid_q, p1_rvalid_d;
    logic             p0_err_q, p0_err_d;
    logic             p1_err_q, p1_err_d;
    logic [CNT_W-1:0] p0_grants_q, p0_grants_d;
    logic [CNT_W-1:0] p1_grants_q, p1_grants_d;

    logic             gnt0_c, gnt1_c;
    logic             sel_we_c;
    logic [AW-1:0]    sel_addr_c;
    logic [DW-1:0]    sel_wdata_c;
    logic             in_range_c;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a locked accept holds the grant, an unlocked one releases it
    always_comb begin
        state_d = state_q;
        if (gnt0_c) begin
            state_d = p0_lock ? ST_LOCK0 : ST_IDLE;
        end else if (gnt1_c) begin
            state_d = p1_lock ? ST_LOCK1 : ST_IDLE;
        end
    end

    // FSM outputs: grant decision; nothing is granted while reset is asserted
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (rstn) begin
            case (state_q)
                ST_IDLE: begin
                    gnt0_c = p0_valid & (~p1_valid | ~rr_q);
                    gnt1_c = p1_valid & (~p0_valid | rr_q);
                end
                ST_LOCK0: gnt0_c = p0_valid;
                ST_LOCK1: gnt1_c = p1_valid;
                default: begin
                    gnt0_c = 1'b0;
                    gnt1_c = 1'b0;
                end
            endcase
        end
    end

    // Mux the granted request onto the RAM port
    always_comb begin
        sel_we_c    = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        if (gnt0_c) begin
            sel_we_c    = p0_we;
            sel_addr_c  = p0_addr;
            sel_wdata_c = p0_wdata;
        end else if (gnt1_c) begin
            sel_we_c    = p1_we;
            sel_addr_c  = p1_addr;
            sel_wdata_c = p1_wdata;
        end
    end

    assign in_range_c = (sel_addr_c < DEPTH_L);
    assign mem_we     = sel_we_c & in_range_c;
    assign mem_addr   = sel_addr_c;
    assign mem_wdata  = sel_wdata_c;
    assign p0_ready   = gnt0_c;
    assign p1_ready   = gnt1_c;

    // Pointer, response tags and grant counters for the next cycle
    always_comb begin
        rr_d        = rr_q;
        if (gnt0_c) begin
            rr_d = 1'b1;
        end else if (gnt1_c) begin
            rr_d = 1'b0;
        end
        p0_rvalid_d = gnt0_c;
        p1_rvalid_d = gnt1_c;
        p0_err_d    = gnt0_c & ~in_range_c;
        p1_err_d    = gnt1_c & ~in_range_c;
        p0_grants_d = p0_grants_q + CNT_W'(gnt0_c);
        p1_grants_d = p1_grants_q + CNT_W'(gnt1_c);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_q        <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_grants_q <= '0;
            p1_grants_q <= '0;
        end else begin
            rr_q        <= rr_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_err_q    <= p0_err_d;
            p1_err_q    <= p1_err_d;
            p0_grants_q <= p0_grants_d;
            p1_grants_q <= p1_grants_d;
        end
    end

    // Responses are squashed while reset is held so a pending one is discarded
    assign p0_rvalid = p0_rvalid_q & rstn;
    assign p1_rvalid = p1_rvalid_q & rstn;
    assign p0_err    = p0_err_q & rstn;
    assign p1_err    = p1_err_q & rstn;
    assign p0_rdata  = (p0_rvalid_q & ~p0_err_q & rstn) ? mem_rdata : '0;
    assign p1_rdata  = (p1_rvalid_q & ~p1_err_q & rstn) ? mem_rdata : '0;
    assign p0_grants = p0_grants_q;
    assign p1_grants = p1_grants_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model plus a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned DEPTH = 262144;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid [2];
    logic        in_we    [2];
    logic        in_lock  [2];
    logic [31:0] in_addr  [2];
    logic [31:0] in_wdata [2];

    logic        p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, ram_rdata;
    logic [31:0] p0_grants, p1_grants;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .p0_valid(in_valid[0]), .p0_ready(p0_ready), .p0_we(in_we[0]), .p0_lock(in_lock[0]),
        .p0_addr(in_addr[0]), .p0_wdata(in_wdata[0]), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_valid(in_valid[1]), .p1_ready(p1_ready), .p1_we(in_we[1]), .p1_lock(in_lock[1]),
        .p1_addr(in_addr[1]), .p1_wdata(in_wdata[1]), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(ram_rdata),
        .p0_grants(p0_grants), .p1_grants(p1_grants)
    );

    // Block RAM: registered read, read-first on write; junk for illegal addresses
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_addr < DEPTH) begin
            ram_rdata <= ram[mem_addr[17:0]];
            if (mem_we) ram[mem_addr[17:0]] <= mem_wdata;
        end else begin
            ram_rdata <= 32'hBAD0_BAD0;
        end
    end

    int          checks = 0;
    int          errors = 0;

    // Reference model state
    int          ptr;
    int          owner;
    logic [31:0] cnt    [2];
    bit          exp_rv [2];
    bit          exp_err[2];
    logic [31:0] exp_rd [2];
    logic [31:0] ref_mem [int unsigned];
    int          exp_g;
    bit          exp_mem_we;
    logic [31:0] exp_mem_addr, exp_mem_wdata;
    bit          cur_rv [2];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // Expected grant and RAM drive for the current inputs
    task automatic predict();
        exp_g = -1;
        if (rstn) begin
            if (owner >= 0) begin
                if (in_valid[owner]) exp_g = owner;
            end else if (in_valid[0] && in_valid[1]) exp_g = ptr;
            else if (in_valid[0]) exp_g = 0;
            else if (in_valid[1]) exp_g = 1;
        end
        exp_mem_we    = (exp_g >= 0) && in_we[exp_g] && (in_addr[exp_g] < DEPTH);
        exp_mem_addr  = (exp_g >= 0) ? in_addr[exp_g] : 32'h0;
        exp_mem_wdata = (exp_g >= 0) ? in_wdata[exp_g] : 32'h0;
        for (int i = 0; i < 2; i++) cur_rv[i] = rstn && exp_rv[i];
    endtask

    // Clock edge: update the model with whatever was accepted, then settle at negedge
    task automatic advance();
        int g;
        predict();
        @(posedge clk);
        if (!rstn) begin
            ptr = 0; owner = -1; cnt[0] = 0; cnt[1] = 0;
            exp_rv[0] = 0; exp_rv[1] = 0;
        end else begin
            exp_rv[0] = 0; exp_rv[1] = 0;
            if (exp_g >= 0) begin
                g = exp_g;
                exp_rv[g]  = 1;
                exp_err[g] = !(in_addr[g] < DEPTH);
                exp_rd[g]  = exp_err[g] ? 32'h0 : ref_read(in_addr[g]);
                if (!exp_err[g] && in_we[g]) ref_mem[in_addr[g]] = in_wdata[g];
                cnt[g] = cnt[g] + 32'd1;
                ptr    = 1 - g;
                owner  = in_lock[g] ? g : -1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 0; in_we[i] = 0; in_lock[i] = 0; in_addr[i] = 0; in_wdata[i] = 0;
        end
    endtask

    task automatic test_reset();
        rstn = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid[0] = 1'($urandom); in_valid[1] = 1'($urandom);
            in_addr[0] = $urandom; in_addr[1] = $urandom;
            in_we[0] = 1; in_we[1] = 1;
            advance();
            #1;
            checks++;
            if ({p0_ready, p1_ready, p0_rvalid, p1_rvalid, mem_we} !== 5'b0) begin
                errors++; $display("FAIL reset_ctl got %b exp 00000", {p0_ready, p1_ready, p0_rvalid, p1_rvalid, mem_we});
            end
            checks++;
            if (mem_addr !== 32'h0 || p0_grants !== 32'h0 || p1_grants !== 32'h0) begin
                errors++; $display("FAIL reset_val addr=%h g0=%h g1=%h exp 0", mem_addr, p0_grants, p1_grants);
            end
        end
        idle_inputs();
        @(negedge clk);
        rstn = 1;
        #1; predict();
        checks++;
        if ({p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we} !== 7'b0 ||
            p0_rdata !== 32'h0 || p1_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL post_reset outputs not all zero rdata0=%h rdata1=%h addr=%h", p0_rdata, p1_rdata, mem_addr);
        end
        advance();
    endtask

    task automatic test_write_read();
        in_valid[0] = 1; in_we[0] = 1; in_addr[0] = 32'd5; in_wdata[0] = 32'hDEAD_BEEF;
        #1; predict();
        checks++;
        if (p0_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd5 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_issue rdy=%b we=%b addr=%h wd=%h exp 1 1 5 deadbeef", p0_ready, mem_we, mem_addr, mem_wdata);
        end
        advance();
        in_we[0] = 0; in_wdata[0] = 0;
        #1; predict();
        checks++;
        if (p0_rvalid !== 1'b1 || p0_err !== 1'b0 || p0_rdata !== init_word(32'd5)) begin
            errors++; $display("FAIL wr_resp rv=%b err=%b rd=%h exp 1 0 %h", p0_rvalid, p0_err, p0_rdata, init_word(32'd5));
        end
        advance();
        in_valid[0] = 0;
        #1; predict();
        checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF || p0_grants !== 32'd2) begin
            errors++; $display("FAIL rd_resp rv=%b rd=%h grants=%0d exp 1 deadbeef 2", p0_rvalid, p0_rdata, p0_grants);
        end
        advance();
        #1;
        checks++;
        if (p0_rvalid !== 1'b0) begin
            errors++; $display("FAIL rd_resp_once rv=%b exp 0", p0_rvalid);
        end
    endtask

    task automatic test_alternate();
        rstn = 0; idle_inputs(); advance(); rstn = 1;
        in_valid[0] = 1; in_valid[1] = 1;
        in_addr[0] = $urandom_range(0, 1023); in_addr[1] = $urandom_range(0, 1023);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin in_valid[0] = 0; in_valid[1] = 0; end
            #1; predict();
            checks++;
            if (k < 4 && ({p0_ready, p1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01))) begin
                errors++; $display("FAIL alt_grant k=%0d got %b", k, {p0_ready, p1_ready});
            end else if (k == 4 && {p0_ready, p1_ready} !== 2'b00) begin
                errors++; $display("FAIL alt_idle got %b exp 00", {p0_ready, p1_ready});
            end
            checks++;
            if ({p0_rvalid, p1_rvalid} !== {cur_rv[0], cur_rv[1]} ||
                (cur_rv[0] && p0_rdata !== exp_rd[0]) || (cur_rv[1] && p1_rdata !== exp_rd[1])) begin
                errors++; $display("FAIL alt_resp k=%0d rv=%b rd0=%h rd1=%h exp rv=%b%b rd0=%h rd1=%h",
                    k, {p0_rvalid, p1_rvalid}, p0_rdata, p1_rdata, cur_rv[0], cur_rv[1], exp_rd[0], exp_rd[1]);
            end
            advance();
            if (k < 4) in_addr[k % 2] = $urandom_range(0, 1023);
        end
        #1;
        checks++;
        if (p0_grants !== 32'd2 || p1_grants !== 32'd2) begin
            errors++; $display("FAIL alt_count g0=%0d g1=%0d exp 2 2", p0_grants, p1_grants);
        end
    endtask

    task automatic test_lock();
        idle_inputs();
        in_valid[1] = 1; in_lock[1] = 1; in_addr[1] = 32'd9;
        #1; predict();
        checks++;
        if (p1_ready !== 1'b1) begin errors++; $display("FAIL lock_take p1_ready=%b exp 1", p1_ready); end
        advance();
        in_valid[1] = 0; in_lock[1] = 0;
        in_valid[0] = 1; in_addr[0] = 32'd7;
        for (int k = 0; k < 3; k++) begin
            #1; predict();
            checks++;
            if (p0_ready !== 1'b0) begin errors++; $display("FAIL lock_hold k=%0d p0_ready=%b exp 0", k, p0_ready); end
            advance();
        end
        in_valid[1] = 1; in_we[1] = 1; in_wdata[1] = $urandom;
        #1; predict();
        checks++;
        if ({p0_ready, p1_ready} !== 2'b01) begin
            errors++; $display("FAIL lock_release got %b exp 01", {p0_ready, p1_ready});
        end
        advance();
        in_valid[1] = 0; in_we[1] = 0;
        #1; predict();
        checks++;
        if (p0_ready !== 1'b1 || p1_rvalid !== 1'b1 || p1_rdata !== exp_rd[1]) begin
            errors++; $display("FAIL lock_after p0_ready=%b p1_rv=%b p1_rd=%h exp 1 1 %h", p0_ready, p1_rvalid, p1_rdata, exp_rd[1]);
        end
        advance();
        in_valid[0] = 0;
        advance();
    endtask

    task automatic test_out_of_range();
        idle_inputs();
        in_valid[0] = 1; in_we[0] = 1; in_addr[0] = DEPTH; in_wdata[0] = 32'h1;
        #1; predict();
        checks++;
        if (p0_ready !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL oor_issue rdy=%b we=%b exp 1 0", p0_ready, mem_we);
        end
        advance();
        in_we[0] = 0; in_addr[0] = 32'd0; in_wdata[0] = 0;
        #1; predict();
        checks++;
        if (p0_rvalid !== 1'b1 || p0_err !== 1'b1 || p0_rdata !== 32'h0) begin
            errors++; $display("FAIL oor_resp rv=%b err=%b rd=%h exp 1 1 0", p0_rvalid, p0_err, p0_rdata);
        end
        advance();
        in_valid[0] = 0;
        #1; predict();
        checks++;
        if (p0_rvalid !== 1'b1 || p0_err !== 1'b0 || p0_rdata !== ref_read(32'd0)) begin
            errors++; $display("FAIL oor_word0 rv=%b err=%b rd=%h exp 1 0 %h", p0_rvalid, p0_err, p0_rdata, ref_read(32'd0));
        end
        advance();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        in_valid[0] = 1; in_addr[0] = 32'd3;
        advance();
        in_valid[0] = 0;
        in_valid[1] = 1; in_lock[1] = 1; in_addr[1] = 32'd4;
        #1; predict();
        checks++;
        if (p1_ready !== 1'b1) begin errors++; $display("FAIL mid_accept p1_ready=%b exp 1", p1_ready); end
        advance();
        idle_inputs();
        rstn = 0;
        #1; predict();
        checks++;
        if (p1_rvalid !== 1'b0) begin errors++; $display("FAIL mid_discard p1_rvalid=%b exp 0", p1_rvalid); end
        advance();
        rstn = 1;
        #1; predict();
        checks++;
        if (p1_rvalid !== 1'b0 || p0_grants !== 32'h0 || p1_grants !== 32'h0) begin
            errors++; $display("FAIL mid_after rv1=%b g0=%0d g1=%0d exp 0 0 0", p1_rvalid, p0_grants, p1_grants);
        end
        advance();
        in_valid[0] = 1; in_valid[1] = 1; in_addr[0] = 32'd1; in_addr[1] = 32'd2;
        for (int k = 0; k < 2; k++) begin
            #1; predict();
            checks++;
            if ({p0_ready, p1_ready} !== ((k == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL mid_ptr k=%0d got %b", k, {p0_ready, p1_ready});
            end
            advance();
            in_valid[k] = 0;
        end
        advance();
    endtask

    task automatic test_wrap();
        idle_inputs();
        force dut.p0_grants_q = 32'hFFFF_FFFF;
        #1 release dut.p0_grants_q;
        cnt[0] = 32'hFFFF_FFFF;
        in_valid[0] = 1; in_addr[0] = 32'd8;
        #1; predict();
        checks++;
        if (p0_grants !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre got %h exp ffffffff", p0_grants); end
        advance();
        in_valid[0] = 0;
        #1; predict();
        checks++;
        if (p0_grants !== 32'h0 || p0_grants !== cnt[0]) begin
            errors++; $display("FAIL wrap_post got %h exp 0", p0_grants);
        end
        advance();
    endtask

    task automatic new_req(input int i);
        in_valid[i] = 1;
        in_we[i]    = 1'($urandom);
        in_lock[i]  = ($urandom_range(0, 5) == 0);
        in_wdata[i] = $urandom;
        case ($urandom_range(0, 9))
            0:       in_addr[i] = DEPTH - 1;
            1:       in_addr[i] = DEPTH;
            2:       in_addr[i] = $urandom;
            default: in_addr[i] = $urandom_range(0, 15);
        endcase
    endtask

    task automatic test_random();
        int g;
        idle_inputs();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) if (!in_valid[i] && $urandom_range(0, 4) < 3) new_req(i);
            #1; predict();
            checks++;
            if ({p0_ready, p1_ready, mem_we, p0_rvalid, p1_rvalid} !==
                {exp_g == 0, exp_g == 1, exp_mem_we, cur_rv[0], cur_rv[1]}) begin
                errors++; $display("FAIL rand_ctl k=%0d got %b exp %b", k, {p0_ready, p1_ready, mem_we, p0_rvalid, p1_rvalid},
                    {exp_g == 0, exp_g == 1, exp_mem_we, cur_rv[0], cur_rv[1]});
            end
            checks++;
            if (mem_addr !== exp_mem_addr || (exp_g >= 0 && mem_wdata !== exp_mem_wdata)) begin
                errors++; $display("FAIL rand_mem k=%0d addr=%h wd=%h exp %h %h", k, mem_addr, mem_wdata, exp_mem_addr, exp_mem_wdata);
            end
            checks++;
            if ((cur_rv[0] && (p0_rdata !== exp_rd[0] || p0_err !== exp_err[0])) ||
                (cur_rv[1] && (p1_rdata !== exp_rd[1] || p1_err !== exp_err[1]))) begin
                errors++; $display("FAIL rand_resp k=%0d rd0=%h e0=%b rd1=%h e1=%b exp %h %b %h %b", k,
                    p0_rdata, p0_err, p1_rdata, p1_err, exp_rd[0], exp_err[0], exp_rd[1], exp_err[1]);
            end
            checks++;
            if (p0_grants !== cnt[0] || p1_grants !== cnt[1]) begin
                errors++; $display("FAIL rand_cnt k=%0d g0=%0d g1=%0d exp %0d %0d", k, p0_grants, p1_grants, cnt[0], cnt[1]);
            end
            g = exp_g;
            advance();
            if (g >= 0) begin
                in_valid[g] = 0;
                in_lock[g]  = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = init_word(32'(i));
        ptr = 0; owner = -1; cnt[0] = 0; cnt[1] = 0;
        exp_rv[0] = 0; exp_rv[1] = 0; exp_err[0] = 0; exp_err[1] = 0;
        exp_rd[0] = 0; exp_rd[1] = 0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_alternate();
        test_lock();
        test_out_of_range();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
